// File: rtl/keycode_pkg.sv
// rtl/keycode_pkg.sv - HID keycodes and FSM state type shared by the keycode input controller.

package keycode_pkg;

   localparam logic [7:0] KC_NONE  = 8'h00;
   localparam logic [7:0] KC_A     = 8'h04;
   localparam logic [7:0] KC_D     = 8'h07;
   localparam logic [7:0] KC_W     = 8'h1A;
   localparam logic [7:0] KC_SPACE = 8'h2C;
   localparam logic [7:0] KC_P     = 8'h13;
   localparam logic [7:0] KC_LEFT  = 8'h50;
   localparam logic [7:0] KC_RIGHT = 8'h4F;
   localparam logic [7:0] KC_UP    = 8'h52;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DIR_HOLD   = 2'd1,
      OTHER_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/keycode_stable_filter.sv
// rtl/keycode_stable_filter.sv - holds a candidate keycode and strobes acceptance once it
// has been stable for STABLE_CYCLES cycles and differs from the currently accepted code.

module keycode_stable_filter #(
   parameter int STABLE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] keycode,
   input  logic [7:0] cur_code,
   output logic       accept_stb,
   output logic [7:0] accept_code
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

   logic [7:0]    cand_q;
   logic [CW-1:0] stab_cnt;
   logic          same;

   assign same = (keycode == cand_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q   <= 8'h00;
         stab_cnt <= '0;
      end else if (!same) begin
         cand_q   <= keycode;
         stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
         stab_cnt <= stab_cnt + CW'(1);
      end
   end

   // Saturation past CNT_ACC keeps a held code from being accepted twice.
   assign accept_stb  = same && (stab_cnt == CNT_ACC) && (cand_q != cur_code);
   assign accept_code = cand_q;

endmodule

// File: rtl/keycode_input_ctrl.sv
// rtl/keycode_input_ctrl.sv - game key decoder: direction levels, action pulses, pause and
// frame-paced auto-repeat. Define KEYCODE_ARROWS_EN to alias arrow keys onto A/D/W.

module keycode_input_ctrl
   import keycode_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000,
   parameter int REPEAT_DELAY  = 15,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [7:0] keycode,
   input  logic       frame_tick,
   output logic [7:0] key_code_q,
   output logic       key_valid,
   output logic       dir_left,
   output logic       dir_right,
   output logic       step_pulse,
   output logic       jump_pulse,
   output logic       paused
);

   localparam int FW = $clog2(REPEAT_DELAY + 1);
   localparam logic [FW-1:0] FRM_LAST   = FW'(REPEAT_DELAY - 1);
   localparam logic [FW-1:0] FRM_RELOAD = FW'(REPEAT_DELAY - REPEAT_PERIOD);

   function automatic logic [7:0] alias_code(input logic [7:0] c);
`ifdef KEYCODE_ARROWS_EN
      case (c)
         KC_LEFT:  return KC_A;
         KC_RIGHT: return KC_D;
         KC_UP:    return KC_W;
         default:  return c;
      endcase
`else
      return c;
`endif
   endfunction

   logic          accept_stb;
   logic [7:0]    accept_code;
   logic [7:0]    map_code;
   logic          is_left, is_right, is_jump, is_p;

   state_t        state, state_d;
   logic [FW-1:0] frm_cnt, frm_cnt_d;
   logic          lvl_left, lvl_left_d, lvl_right, lvl_right_d;
   logic          paused_d, step_d, jump_d;

   keycode_stable_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clk         (clk_clk),
      .rst_n       (reset_reset_n),
      .keycode     (keycode),
      .cur_code    (key_code_q),
      .accept_stb  (accept_stb),
      .accept_code (accept_code)
   );

   assign map_code = alias_code(accept_code);
   assign is_left  = (map_code == KC_A);
   assign is_right = (map_code == KC_D);
   assign is_jump  = (map_code == KC_W) || (map_code == KC_SPACE);
   assign is_p     = (map_code == KC_P);

   always_comb begin
      state_d     = state;
      frm_cnt_d   = frm_cnt;
      lvl_left_d  = lvl_left;
      lvl_right_d = lvl_right;
      paused_d    = paused;
      step_d      = 1'b0;
      jump_d      = 1'b0;
      // Acceptance takes priority over a coincident frame_tick.
      if (accept_stb) begin
         frm_cnt_d   = '0;
         lvl_left_d  = is_left;
         lvl_right_d = is_right;
         jump_d      = is_jump;
         if (is_p)
            paused_d = ~paused;
         if (is_left || is_right) begin
            state_d = DIR_HOLD;
            step_d  = 1'b1;
         end else if (accept_code == KC_NONE) begin
            state_d = IDLE;
         end else begin
            state_d = OTHER_HOLD;
         end
      end else if (state == DIR_HOLD && frame_tick) begin
         if (frm_cnt == FRM_LAST) begin
            step_d    = 1'b1;
            frm_cnt_d = FRM_RELOAD;
         end else begin
            frm_cnt_d = frm_cnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state      <= IDLE;
         frm_cnt    <= '0;
         lvl_left   <= 1'b0;
         lvl_right  <= 1'b0;
         key_code_q <= 8'h00;
         key_valid  <= 1'b0;
         paused     <= 1'b0;
         dir_left   <= 1'b0;
         dir_right  <= 1'b0;
         step_pulse <= 1'b0;
         jump_pulse <= 1'b0;
      end else begin
         state      <= state_d;
         frm_cnt    <= frm_cnt_d;
         lvl_left   <= lvl_left_d;
         lvl_right  <= lvl_right_d;
         paused     <= paused_d;
         if (accept_stb) begin
            key_code_q <= accept_code;
            key_valid  <= (accept_code != KC_NONE);
         end
         dir_left   <= lvl_left_d  & ~paused_d;
         dir_right  <= lvl_right_d & ~paused_d;
         step_pulse <= step_d      & ~paused_d;
         jump_pulse <= jump_d      & ~paused_d;
      end
   end

endmodule

// File: doc/keycode_input_ctrl.md
Name: keycode_input_ctrl

Overview:
- Consumes the 8-bit USB HID keycode that the Nios system publishes on its keycode PIO, on the same clock.
- Filters out transient keycode values and decodes a small game key map.
- Produces direction levels, single-cycle action pulses, a pause toggle, and frame-paced auto-repeat steps for the game logic and sprite stages.

Parameters:
- STABLE_CYCLES, 50000: consecutive clock cycles a new keycode must hold before it is accepted (1 ms at 50 MHz).
- REPEAT_DELAY, 15: frame_tick count after acceptance before the first auto-repeat step.
- REPEAT_PERIOD, 4: frame_tick count between subsequent auto-repeat steps.

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  asynchronous active-low reset
- keycode  in  8  HID keycode from the Nios keycode PIO; 0x00 means no key
- frame_tick  in  1  one-cycle pulse per video frame
- key_code_q  out  8  currently accepted keycode
- key_valid  out  1  accepted keycode is non-zero
- dir_left  out  1  level: accepted key is A (0x04)
- dir_right  out  1  level: accepted key is D (0x07)
- step_pulse  out  1  one-cycle pulse on direction acceptance and on each auto-repeat
- jump_pulse  out  1  one-cycle pulse on acceptance of W (0x1A) or Space (0x2C)
- paused  out  1  toggles on each acceptance of P (0x13)

Behaviour:
- Reset state:
  - Reset is asynchronous, active-low.
  - All outputs are 0; FSM is in IDLE; all counters are 0; the candidate register is 0x00.
- Input stage:
  - keycode is registered once into cand_q.
  - stab_cnt, of width $clog2(STABLE_CYCLES+1), counts cycles in which keycode == cand_q, and saturates at STABLE_CYCLES.
  - Any difference between keycode and cand_q reloads cand_q and clears stab_cnt.
- Acceptance:
  - Acceptance occurs when stab_cnt reaches STABLE_CYCLES-1 while keycode == cand_q and cand_q != key_code_q.
  - key_code_q is updated on that same edge.
  - Latency: a new value first present before edge N is accepted at edge N+STABLE_CYCLES.
  - Re-acceptance of an unchanged code never occurs.
- FSM states: IDLE, DIR_HOLD, OTHER_HOLD.
  - On acceptance of A or D, go to DIR_HOLD: pulse step_pulse and clear frm_cnt.
  - On acceptance of W, Space, P, or any other non-zero code, go to OTHER_HOLD.
  - On acceptance of 0x00, go to IDLE.
  - Direct transitions between codes (e.g. A to D with no intervening 0x00) are legal: the old code is released and the new code pressed on the same edge.
- Auto-repeat (DIR_HOLD only):
  - frm_cnt increments on frame_tick.
  - On reaching REPEAT_DELAY, pulse step_pulse and reload frm_cnt to REPEAT_DELAY-REPEAT_PERIOD; subsequent steps therefore come every REPEAT_PERIOD ticks.
  - frm_cnt width is $clog2(REPEAT_DELAY+1).
- Simultaneous events: if acceptance and frame_tick occur on the same edge, acceptance wins; frm_cnt is cleared and the tick is ignored.
- paused:
  - Toggles on the acceptance edge of P only; holding P does not re-toggle.
  - While paused = 1, dir_left, dir_right, step_pulse and jump_pulse are forced to 0.
  - key_code_q, key_valid and the FSM keep running while paused.
- Reset mid-hold: everything returns to the reset state. A key still held after reset is re-accepted after STABLE_CYCLES and produces fresh pulses.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: KEYCODE_ARROWS_EN.
- When defined:
  - Left arrow (0x50) aliases to A, right arrow (0x4F) to D, up arrow (0x52) to W.
  - Aliased codes drive dir_left, dir_right, step_pulse and jump_pulse identically to their letter equivalents.
  - key_code_q still reports the raw code.
- When undefined: arrow codes are treated as "other" keys (OTHER_HOLD, no pulses).

Decomposition:
- Package keycode_pkg holds:
  - the localparam HID codes KC_NONE, KC_A, KC_D, KC_W, KC_SPACE, KC_P, KC_LEFT, KC_RIGHT, KC_UP;
  - the FSM state enum typedef.
- One sub-module, keycode_stable_filter: owns cand_q and stab_cnt, and outputs accept_stb plus the accepted code.
- The top module holds the FSM, the repeat counter and the pause logic.

Test Plan (STABLE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2):
- Reset release, then keycode=0x04 held from before edge N → key_code_q=0x04 and dir_left=1 at edge N+4, with step_pulse high for exactly that cycle.
- keycode=0x04 toggling to 0x00 every 2 cycles for 20 cycles → key_code_q stays 0x00; no pulses.
- keycode=0x07 held, frame_tick every 10 cycles → steps at acceptance, then on the 3rd, 5th and 7th ticks; 0x00 thereafter → dir_right drops 4 cycles later and steps stop.
- Press 0x13, release, press 0x13 again, each held 6+ cycles → paused goes 1 then 0; while paused, 0x2C produces no jump_pulse.
- keycode switched 0x04 → 0x07 directly, with frame_tick coincident with the acceptance edge → dir_left falls and dir_right rises on the same edge; one step_pulse; frm_cnt=0.
- reset_reset_n asserted mid-DIR_HOLD with 0x04 still present → all outputs 0 immediately; after release, dir_left returns 4 cycles later. With KEYCODE_ARROWS_EN, 0x50 gives the same result as 0x04.
